pio_fabric: RTL
===============

# pio_fabric

Parametrised PIO fabric between the host bridge and N peripheral blocks. It replaces the fixed one-slave hookup of the host PIO master. It accepts one PIO request at a time, decodes the address into one of NUM_SLAVES equal power-of-two windows, and drives the selected slave until it acknowledges. It returns read data to the master, or an error response on decode miss or slave timeout.

## Interface
Parameters:
- NUM_SLAVES, 4: number of slave channels, 1..16.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- BASE, 32'h0000_0000: start of slave window 0.
- SLV_SIZE, 32'h0100_0000: bytes per slave window; must be a power of two.
- TIMEOUT, 16: maximum cycles s_sel is held without ack; must be ≥1.
- ERR_DATA, 32'hDEAD_BEEF: m_rdata value on an error response.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- m_req  in  1  single-cycle request pulse from the host.
- m_wr  in  1  1 = write, 0 = read; sampled with m_req.
- m_addr  in  ADDR_W  request address.
- m_wdata  in  DATA_W  write data.
- m_busy  out  1  high whenever the FSM is not IDLE.
- m_ack  out  1  single-cycle response strobe.
- m_err  out  1  error flag, valid with m_ack.
- m_rdata  out  DATA_W  read data, valid with m_ack, held until the next m_ack.
- s_sel  out  NUM_SLAVES  one-hot slave select, level.
- s_wr  out  1  latched write flag.
- s_addr  out  ADDR_W  latched offset within the slave window (m_addr − window base).
- s_wdata  out  DATA_W  latched write data.
- s_ack  in  NUM_SLAVES  per-slave acknowledge.
- s_rdata  in  NUM_SLAVES*DATA_W  packed read data; slave i occupies bits [i*DATA_W +: DATA_W].

## Operation
- FSM states are IDLE, ACCESS and RESP.
- IDLE: when m_req=1, the block latches m_wr, m_addr and m_wdata, then computes idx = (m_addr − BASE) / SLV_SIZE as an unsigned subtraction.
  - Hit: m_addr ≥ BASE and idx < NUM_SLAVES. The FSM goes to ACCESS, and s_sel[idx] is set.
  - Miss: the FSM goes to RESP with err=1 and rdata=ERR_DATA.
- ACCESS: s_sel[idx] is held. Only s_ack[idx] is observed; acks from other slaves are ignored.
  - On s_ack[idx]=1, the block captures s_rdata slice idx for a read, or 0 for a write. It clears s_sel and goes to RESP with err=0.
  - Timeout: the timer counts ACCESS cycles without ack. When it reaches TIMEOUT, s_sel clears and the FSM goes to RESP with err=1 and rdata=ERR_DATA.
  - If s_ack arrives in the last allowed cycle, the ack wins and no error is reported.
- RESP: m_ack=1 for exactly one cycle, with m_err and m_rdata as above. The FSM then returns to IDLE.
- m_req pulses while m_busy=1 are dropped. No queueing; the host must wait for m_ack.
- s_wr, s_addr and s_wdata are registered at acceptance and remain stable until the next acceptance.

## Timing
- Reset (asynchronous): state=IDLE, s_sel=0, m_ack=0, m_err=0, m_busy=0, m_rdata=0, s_wr=0, s_addr=0, s_wdata=0, timer=0. Assertion mid-access drops s_sel immediately.
- Request sampled at edge 0:
  - Hit: s_sel is high from cycle 1.
  - Miss: m_ack=1, m_err=1 in cycle 1.
- Slave ack sampled in cycle k (k ≥ 1; a combinational ack is allowed): m_ack is high in cycle k+1 and s_sel is low in cycle k+1.
- Minimum hit latency is 2 cycles from m_req to m_ack. Back-to-back requests are possible every 3 cycles: m_req may be asserted in the cycle after m_ack.
- Timeout: with no ack, s_sel is high for exactly TIMEOUT cycles (1..TIMEOUT). m_ack with m_err=1 occurs in cycle TIMEOUT+1.

## Configuration
- PIO_FABRIC_TIMEOUT_EN defined: the timeout counter and timeout error path are present, as described above.
- PIO_FABRIC_TIMEOUT_EN undefined: no counter. ACCESS waits indefinitely for s_ack[idx], and m_err is only ever set by a decode miss.

## Test plan
- Read hit: m_addr=32'h0200_0010, read; slave 2 acks in cycle 1 with 32'h1234_5678. Required: s_sel=4'b0100 in cycle 1, s_addr=32'h10; m_ack=1, m_err=0, m_rdata=32'h1234_5678 in cycle 2.
- Write hit with slow slave: m_addr=32'h0300_0004, wr, m_wdata=32'hA5A5_A5A5; slave 3 acks after 5 cycles. Required: s_sel=4'b1000 for cycles 1..5, s_wdata held, m_ack in cycle 6, m_rdata=0.
- Decode miss: m_addr=32'h0400_0000 with NUM_SLAVES=4. Required: m_ack=1, m_err=1, m_rdata=32'hDEAD_BEEF in cycle 1; s_sel never set.
- Timeout (TIMEOUT_EN, TIMEOUT=16): slave 1 never acks. Required: s_sel=4'b0010 for cycles 1..16, then m_ack=1 with m_err=1 in cycle 17. Repeat with the ack in cycle 16: m_err=0.
- Ignored events: m_req pulsed while m_busy=1 produces no second response. s_ack[0] asserted while slave 2 is selected has no effect.
- Reset mid-ACCESS: assert reset while s_sel=4'b0001. Required: s_sel=0 and m_busy=0 immediately. After release, a new read to slave 0 completes normally.

Source files
------------

// File: rtl/pio_fabric.sv
// pio_fabric: routes one host PIO request at a time onto one of NUM_SLAVES power-of-two windows.
// Optional slave timeout present when PIO_FABRIC_TIMEOUT_EN is defined.
module pio_fabric #(
  parameter int                NUM_SLAVES = 4,
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE       = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] SLV_SIZE   = 32'h0100_0000,
  parameter int                TIMEOUT    = 16,
  parameter logic [DATA_W-1:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         m_req,
  input  logic                         m_wr,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  output logic                         m_busy,
  output logic                         m_ack,
  output logic                         m_err,
  output logic [DATA_W-1:0]            m_rdata,
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic                         s_wr,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic [NUM_SLAVES-1:0]        s_ack,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata
);

  localparam int                SH       = $clog2(SLV_SIZE);
  localparam int                IDX_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = SLV_SIZE - ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx_q;
  logic [ADDR_W-1:0]  off, win;
  logic               hit;
  logic               accept;
  logic               resp_load;
  logic               resp_err;
  logic [DATA_W-1:0]  resp_data;
  logic               slv_ack;
  logic [DATA_W-1:0]  slv_rdata;

  // Unsigned subtraction; addresses below BASE wrap and are rejected by the >= test.
  assign off = m_addr - BASE;
  assign win = off >> SH;
  assign hit = (m_addr >= BASE) && (win < ADDR_W'(NUM_SLAVES));

  assign m_busy = (state != IDLE);
  assign m_ack  = (state == RESP);

`ifdef PIO_FABRIC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (state == ACCESS) begin
      timer <= timer + TW'(1);
    end else begin
      timer <= '0;
    end
  end
`endif

  // Only the selected slave's ack and data are visible to the FSM.
  always_comb begin
    slv_ack   = 1'b0;
    slv_rdata = '0;
    s_sel     = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        slv_ack   = s_ack[i];
        slv_rdata = s_rdata[i*DATA_W +: DATA_W];
        s_sel[i]  = (state == ACCESS);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    resp_load = 1'b0;
    resp_err  = 1'b0;
    resp_data = '0;
    case (state)
      IDLE: begin
        if (m_req) begin
          accept = 1'b1;
          if (hit) begin
            state_nxt = ACCESS;
          end else begin
            state_nxt = RESP;
            resp_load = 1'b1;
            resp_err  = 1'b1;
            resp_data = ERR_DATA;
          end
        end
      end
      ACCESS: begin
        // An ack in the final allowed cycle takes priority over the timeout.
        if (slv_ack) begin
          state_nxt = RESP;
          resp_load = 1'b1;
          resp_data = s_wr ? '0 : slv_rdata;
        end
`ifdef PIO_FABRIC_TIMEOUT_EN
        else if (timer == TW'(TIMEOUT - 1)) begin
          state_nxt = RESP;
          resp_load = 1'b1;
          resp_err  = 1'b1;
          resp_data = ERR_DATA;
        end
`endif
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      s_wr    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      m_err   <= 1'b0;
      m_rdata <= '0;
    end else begin
      if (accept) begin
        idx_q   <= IDX_W'(win);
        s_wr    <= m_wr;
        s_addr  <= off & OFF_MASK;
        s_wdata <= m_wdata;
      end
      if (resp_load) begin
        m_err   <= resp_err;
        m_rdata <= resp_data;
      end
    end
  end

endmodule
